// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
//
// Top-level sequencer for the Dino game. Converts the start button and the
// collision flag into one-cycle game_start / game_over pulses, gates the
// 60 Hz frame pulse into a score tick, times the death animation and the
// restart lockout, and keeps a BCD high score plus a difficulty level that
// follows the hundreds digit of the running score.
//
// Parameters
//   DEATH_FRAMES   : frames spent in DEAD before OVER (1..255)
//   RESTART_FRAMES : frames in OVER during which start presses are ignored
//                    (0..255)
//   MAX_LEVEL      : saturation value of speed_level (<= 7)
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   btn_start    in   debounced start button level (high = pressed)
//   collision    in   collision level, only looked at in RUN
//   frame_end    in   one-cycle pulse at the end of every frame
//   score  [15:0] in  4-digit packed BCD score from the score counter
//   game_start   out  one-cycle pulse when a game begins
//   game_over    out  one-cycle pulse when a game ends
//   score_tick   out  frame_end delayed one cycle, only while running
//   state  [1:0] out  0 IDLE, 1 RUN, 2 DEAD, 3 OVER
//   freeze       out  high in DEAD and OVER, stops all motion
//   speed_level [2:0] out  difficulty level 0..MAX_LEVEL
//   hi_score [15:0] out   best score since power-on/reset, packed BCD
// -----------------------------------------------------------------------------
module game_ctrl #(
   parameter int unsigned DEATH_FRAMES   = 30,
   parameter int unsigned RESTART_FRAMES = 15,
   parameter int unsigned MAX_LEVEL      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        collision,
   input  logic        frame_end,
   input  logic [15:0] score,
   output logic        game_start,
   output logic        game_over,
   output logic        score_tick,
   output logic [1:0]  state,
   output logic        freeze,
   output logic [2:0]  speed_level,
   output logic [15:0] hi_score
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2,
      S_OVER = 2'd3
   } state_t;

   // The DEAD exit fires on the frame that brings the count to DEATH_FRAMES,
   // i.e. while the counter still holds DEATH_FRAMES-1.
   localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] RESTART_CNT = 8'(RESTART_FRAMES);
   localparam logic [2:0] LEVEL_MAX   = 3'(MAX_LEVEL);

   state_t      st;
   logic        btn_q;
   logic [7:0]  frame_cnt;
   logic [3:0]  digit_q;

   logic        press;
   logic [3:0]  digit;

   // Rising edge of the (already debounced) button; a held button is one press.
   assign press = btn_start & ~btn_q;
   assign digit = score[11:8];
   assign state = st;

   // NOTE: every register below is assigned with <= so that all of them see
   // the pre-edge values of each other, exactly like the hardware flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_IDLE;
         btn_q       <= 1'b0;
         frame_cnt   <= 8'd0;
         digit_q     <= 4'd0;
         game_start  <= 1'b0;
         game_over   <= 1'b0;
         score_tick  <= 1'b0;
         freeze      <= 1'b0;
         speed_level <= 3'd0;
         hi_score    <= 16'h0000;
      end else begin
         btn_q      <= btn_start;
         // Pulses default low; a branch below raises one for a single cycle.
         game_start <= 1'b0;
         game_over  <= 1'b0;
         score_tick <= 1'b0;

         // First DEAD cycle: game_over is still high, score is final.
         // Packed BCD compares correctly as plain unsigned binary.
         if (st == S_DEAD && game_over && score > hi_score) begin
            hi_score <= score;
         end

         case (st)
            S_IDLE: begin
               if (press) begin
                  st          <= S_RUN;
                  game_start  <= 1'b1;
                  speed_level <= 3'd0;
                  digit_q     <= digit;
                  frame_cnt   <= 8'd0;
               end
            end

            S_RUN: begin
               // Any change of the hundreds digit (including the 9999->0
               // wrap) bumps the level once; it never goes down in a game.
               if (digit != digit_q && speed_level < LEVEL_MAX) begin
                  speed_level <= speed_level + 3'd1;
               end
               digit_q <= digit;

               // Collision wins over both a coincident frame and a press.
               if (collision) begin
                  st        <= S_DEAD;
                  game_over <= 1'b1;
                  freeze    <= 1'b1;
                  frame_cnt <= 8'd0;
               end else begin
                  score_tick <= frame_end;
               end
            end

            S_DEAD: begin
               if (frame_end) begin
                  if (frame_cnt == DEATH_LAST) begin
                     st        <= S_OVER;
                     frame_cnt <= 8'd0;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end

            S_OVER: begin
               // Presses during the lockout are dropped, not queued.
               if (press && frame_cnt == RESTART_CNT) begin
                  st          <= S_RUN;
                  game_start  <= 1'b1;
                  freeze      <= 1'b0;
                  frame_cnt   <= 8'd0;
                  speed_level <= 3'd0;
                  digit_q     <= digit;
               end else if (frame_end && frame_cnt < RESTART_CNT) begin
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end

            default: begin
               st <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
//
// Directed bench for game_ctrl. A behavioural model tracks the game phase,
// frames seen in the current phase, level and best score using plain
// integers; every cycle after reset its expectations are compared with the
// DUT outputs. Hand-computed literal checks at key points pin the model.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

   localparam int DEATH   = 30;
   localparam int RESTART = 15;
   localparam int MAXL    = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_start;
   logic        collision;
   logic        frame_end;
   logic [15:0] score;
   logic        game_start;
   logic        game_over;
   logic        score_tick;
   logic [1:0]  state;
   logic        freeze;
   logic [2:0]  speed_level;
   logic [15:0] hi_score;

   game_ctrl #(
      .DEATH_FRAMES  (DEATH),
      .RESTART_FRAMES(RESTART),
      .MAX_LEVEL     (MAXL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .collision  (collision),
      .frame_end  (frame_end),
      .score      (score),
      .game_start (game_start),
      .game_over  (game_over),
      .score_tick (score_tick),
      .state      (state),
      .freeze     (freeze),
      .speed_level(speed_level),
      .hi_score   (hi_score)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 running, 2 dying, 3 game over screen
   int          m_state  = 0;
   int          m_frames = 0;
   int          m_level  = 0;
   int          m_dig    = 0;
   int          m_hi     = 0;
   bit          m_btn    = 0;
   bit          m_gs     = 0;
   bit          m_go     = 0;
   bit          m_tick   = 0;

   always @(posedge clk) begin
      int  nxt;
      int  dig;
      bit  pressed;
      bit  was_go;
      pressed = btn_start && !m_btn;
      dig     = (int'(score) / 256) % 16;
      if (rst) begin
         m_state  = 0;
         m_frames = 0;
         m_level  = 0;
         m_dig    = 0;
         m_hi     = 0;
         m_gs     = 0;
         m_go     = 0;
         m_tick   = 0;
         m_btn    = 0;
      end else begin
         was_go = m_go;
         m_gs   = 0;
         m_go   = 0;
         m_tick = 0;
         nxt    = m_state;
         // best score is taken on the cycle right after the game ended
         if (m_state == 2 && was_go && int'(score) > m_hi) m_hi = int'(score);
         case (m_state)
            0: if (pressed) begin nxt = 1; m_gs = 1; end
            1: begin
               if (collision) begin nxt = 2; m_go = 1; end
               else m_tick = frame_end;
            end
            2: if (frame_end) begin
               m_frames++;
               if (m_frames == DEATH) nxt = 3;
            end
            default: begin
               if (pressed && m_frames >= RESTART) begin nxt = 1; m_gs = 1; end
               else if (frame_end && m_frames < RESTART) m_frames++;
            end
         endcase
         if (nxt == 1 && m_state != 1) begin
            m_level = 0;
            m_dig   = dig;
         end else if (m_state == 1) begin
            if (dig != m_dig && m_level < MAXL) m_level++;
            m_dig = dig;
         end
         if (nxt != m_state) m_frames = 0;
         m_state = nxt;
         m_btn   = btn_start;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en   = 0;
   int gs_cnt   = 0;
   int go_cnt   = 0;
   int tick_cnt = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("state",       32'(state),       32'(m_state));
         check("game_start",  32'(game_start),  32'(m_gs));
         check("game_over",   32'(game_over),   32'(m_go));
         check("score_tick",  32'(score_tick),  32'(m_tick));
         check("freeze",      32'(freeze),      32'(m_state >= 2));
         check("speed_level", 32'(speed_level), 32'(m_level));
         check("hi_score",    32'(hi_score),    32'(m_hi));
         if (game_start) gs_cnt++;
         if (game_over)  go_cnt++;
         if (score_tick) tick_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_frames(input int n);
      repeat (n) begin
         frame_end = 1'b1;
         step();
         frame_end = 1'b0;
         step();
      end
   endtask

   task automatic die();
      collision = 1'b1;
      step();
      collision = 1'b0;
      step();
   endtask

   task automatic restart_game();
      pulse_frames(DEATH);
      pulse_frames(RESTART);
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
   endtask

   initial begin
      int gs_before;
      int go_before;
      rst       = 1'b1;
      btn_start = 1'b0;
      collision = 1'b0;
      frame_end = 1'b0;
      score     = 16'h0000;
      step(2);
      cmp_en = 1;
      check("reset_state",  32'(state),       32'd0);
      check("reset_hi",     32'(hi_score),    32'h0);
      check("reset_level",  32'(speed_level), 32'd0);
      check("reset_freeze", 32'(freeze),      32'd0);
      rst = 1'b0;
      step();

      // Held button: exactly one start.
      btn_start = 1'b1;
      step(100);
      check("held_start_pulses", 32'(gs_cnt), 32'd1);
      check("run_state", 32'(state), 32'd1);
      check("run_level", 32'(speed_level), 32'd0);
      btn_start = 1'b0;
      step();

      // Five frames, each tick one cycle later.
      for (int i = 0; i < 5; i++) begin
         frame_end = 1'b1;
         step();
         check("tick_after_frame", 32'(score_tick), 32'd1);
         frame_end = 1'b0;
         step();
         check("tick_one_cycle", 32'(score_tick), 32'd0);
      end
      check("tick_count", 32'(tick_cnt), 32'd5);

      // Death at 0123 coincident with a sixth frame.
      score = 16'h0123;
      step(2);
      collision = 1'b1;
      frame_end = 1'b1;
      step();
      collision = 1'b0;
      frame_end = 1'b0;
      check("over_pulse",   32'(game_over),  32'd1);
      check("dead_state",   32'(state),      32'd2);
      check("dead_freeze",  32'(freeze),     32'd1);
      check("no_sixth_tick",32'(score_tick), 32'd0);
      step();
      check("tick_count_after_death", 32'(tick_cnt), 32'd5);
      check("hi_first", 32'(hi_score), 32'h0123);

      // DEAD lasts exactly 30 frames.
      pulse_frames(DEATH - 1);
      check("dead_after_29", 32'(state), 32'd2);
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      check("over_after_30", 32'(state), 32'd3);
      step();

      // Lockout: press after 10 frames ignored, after 15 accepted.
      pulse_frames(10);
      score     = 16'h0000;
      gs_before = gs_cnt;
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
      check("early_press_state", 32'(state), 32'd3);
      check("early_press_start", 32'(gs_cnt), 32'(gs_before));
      pulse_frames(5);
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      check("restart_pulse", 32'(game_start), 32'd1);
      check("restart_state", 32'(state), 32'd1);
      step();

      // Second game dies lower: best score holds.
      score = 16'h0099;
      step(2);
      die();
      check("hi_kept", 32'(hi_score), 32'h0123);

      // Third game: difficulty follows the hundreds digit.
      restart_game();
      check("level_new_game", 32'(speed_level), 32'd0);
      for (int i = 1; i <= 9; i++) begin
         score = 16'(i) << 8;
         step(2);
         check("level_step", 32'(speed_level), (i > 7) ? 32'd7 : 32'(i));
      end
      check("level_sat", 32'(speed_level), 32'd7);
      die();
      check("hi_0900", 32'(hi_score), 32'h0900);
      score = 16'h0000;
      restart_game();
      check("level_cleared", 32'(speed_level), 32'd0);

      // Reset while dying at 0500.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("hi_after_reset", 32'(hi_score), 32'h0);
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
      score = 16'h0500;
      step(2);
      die();
      check("hi_0500", 32'(hi_score), 32'h0500);
      check("dead_before_rst", 32'(state), 32'd2);
      go_before = go_cnt;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_state",  32'(state),     32'd0);
      check("rst_hi",     32'(hi_score),  32'h0);
      check("rst_freeze", 32'(freeze),    32'd0);
      step(3);
      check("rst_no_over", 32'(go_cnt), 32'(go_before));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the Dino datapath. Turns the player's start button and the collision flag into one-cycle `game_start`/`game_over` pulses for the score counter. Gates the 60 Hz frame pulse into a score tick and times the death and restart-lockout phases. Also maintains a BCD high score and a difficulty level derived from the running score. Sits between input conditioning / collision detection and the score, obstacle-speed and display logic.

## Interface
- `DEATH_FRAMES`, 30: frames spent in DEAD (freeze/flash animation) before OVER; legal range 1..255.
- `RESTART_FRAMES`, 15: frames in OVER during which start presses are ignored; legal range 0..255.
- `MAX_LEVEL`, 7: saturation value of `speed_level`; must be ≤ 7.
- `clk` in 1: system clock; one clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `btn_start` in 1: debounced start/jump button, level, high = pressed.
- `collision` in 1: level from collision detect, sampled only in RUN.
- `frame_end` in 1: one-cycle pulse at end of each 60 Hz frame.
- `score` in 16: 4-digit packed BCD from the score counter (`[15:12]` thousands … `[3:0]` units).
- `game_start` out 1: one-cycle pulse, start of a game.
- `game_over` out 1: one-cycle pulse, end of a game.
- `score_tick` out 1: registered copy of `frame_end`, qualified by state RUN.
- `state` out 2: 0 IDLE, 1 RUN, 2 DEAD, 3 OVER.
- `freeze` out 1: high in DEAD and OVER; stops sprite/obstacle motion.
- `speed_level` out 3: difficulty level, 0..`MAX_LEVEL`.
- `hi_score` out 16: best score this power-on, packed BCD.

## Operation
- Button edge: register `btn_start` once; `press` = `btn_start & ~btn_q`. A held button never retriggers.
- IDLE: on `press` → RUN; assert `game_start` in the same registered update that enters RUN.
- RUN: if `collision` → DEAD, assert `game_over`, clear the frame counter. `score_tick` = `frame_end`, registered, only while `state`==RUN and no collision that cycle.
- DEAD: count `frame_end` pulses. When the count reaches `DEATH_FRAMES` → OVER and clear the counter. `press` is ignored.
- OVER: count `frame_end` up to `RESTART_FRAMES`, saturating. Once the count equals `RESTART_FRAMES`, `press` → RUN with a `game_start` pulse. Earlier presses are dropped and not remembered.
- High score: in the cycle after the `game_over` pulse (first DEAD cycle), if `score` > `hi_score` as unsigned 16-bit, load `hi_score` ← `score`. BCD ordering equals binary ordering, so no BCD arithmetic is needed.
- Speed level: cleared to 0 on `game_start`. In RUN, register the hundreds digit `score[11:8]`. Whenever the current value differs from the registered value, increment `speed_level`, saturating at `MAX_LEVEL`. A score wrap (9999→0) changes the digit and counts as one increment; the level never decrements within a game.
- Frame counter: 8 bits, shared by DEAD and OVER, cleared on every state change.

## Timing
- Reset: `state`=IDLE; `game_start`, `game_over`, `score_tick`, `freeze`=0; `speed_level`=0; `hi_score`=16'h0000; counters and `btn_q` = 0.
- All outputs are registered.
- `press` sampled at edge N → `game_start`=1 and `state`=RUN after edge N+1.
- `collision` sampled at edge N → `game_over`=1, `state`=DEAD, `freeze`=1 after edge N+1; `hi_score` updates after N+2.
- `frame_end` at edge N → `score_tick` after N+1 (RUN only).
- `collision` and `frame_end` in the same cycle: collision wins and no `score_tick` is issued for that frame.
- `press` and `collision` in the same RUN cycle: collision wins; `press` is ignored.
- `rst` mid-game: returns to IDLE next edge. `hi_score` is cleared; no `game_over` pulse is emitted.
- `game_start` and `game_over` are never high in the same cycle.

## Test plan
- Reset, then `btn_start` held high for 100 cycles → exactly one `game_start` pulse, `state`=1, `speed_level`=0.
- In RUN, 5 `frame_end` pulses → 5 `score_tick` pulses, each 1 cycle after its `frame_end`. Then `collision` coincident with a 6th `frame_end` → `game_over` pulse, no 6th tick, `state`=2, `freeze`=1.
- `score`=16'h0123 at death with `hi_score`=0 → `hi_score`=16'h0123. Next game dies at 16'h0099 → `hi_score` stays 16'h0123.
- DEATH_FRAMES=30 → `state` goes to 3 right after the 30th `frame_end` in DEAD. RESTART_FRAMES=15: a press after 10 frames → no start; a press after 15 frames → `game_start`, `state`=1.
- Drive `score` 16'h0099→0100→0200→…→0900 in RUN → `speed_level` 1,2,…,7, then stays 7. A new `game_start` → 0.
- Assert `rst` for 1 cycle while in DEAD with `hi_score`=16'h0500 → `state`=0, `hi_score`=0, no `game_over` pulse.
